// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//   Parallel-to-serial converter. It accepts WIDTH-bit words over a
//   valid/ready handshake and emits them one bit per cycle on a registered
//   serial line. A one-word holding register lets the next word be queued
//   while the current word shifts, so back-to-back words leave no gap.
//
// Parameters
//   WIDTH      bits per parallel word (2..16)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   CLK         clock, all state updates on the rising edge
//   RESET       synchronous active-high reset
//   LOAD_DATA   parallel word offered by upstream
//   LOAD_VALID  LOAD_DATA is valid this cycle
//   LOAD_READY  block can accept a word this cycle (= ~HOLD_FULL)
//   SDATA       serial bit stream, 0 while idle
//   SVALID      SDATA carries a payload bit this cycle
//   BUSY        shifter active or holding register occupied
// -----------------------------------------------------------------------------
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             SDATA,
    output logic             SVALID,
    output logic             BUSY
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   shifter_q,   shifter_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0]   hold_q,      hold_d;
    logic               hold_full_q, hold_full_d;
    logic               sdata_q,     sdata_d;
    logic               svalid_q,    svalid_d;

    logic               accept;
    logic               do_load;
    logic [WIDTH-1:0]   load_word;

    // Bit that goes out first for a given word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit consumed, so the next bit to send sits at the head.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign LOAD_READY = ~hold_full_q;
    assign accept     = LOAD_VALID & LOAD_READY;
    assign SDATA      = sdata_q;
    assign SVALID     = svalid_q;
    assign BUSY       = (state_q == SHIFT) | hold_full_q;

    // The serial output is registered: on a load the head bit is written to
    // sdata_q directly and the shifter keeps only the bits not yet sent.
    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sdata_d     = sdata_q;
        svalid_d    = svalid_q;
        do_load     = 1'b0;
        load_word   = '0;

        unique case (state_q)
            IDLE: begin
                sdata_d  = 1'b0;
                svalid_d = 1'b0;
                if (accept) begin
                    do_load   = 1'b1;
                    load_word = LOAD_DATA;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (hold_full_q) begin
                        do_load     = 1'b1;
                        load_word   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        // Direct reload bypasses the holding register.
                        do_load   = 1'b1;
                        load_word = LOAD_DATA;
                    end else begin
                        state_d   = IDLE;
                        sdata_d   = 1'b0;
                        svalid_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end else begin
                    sdata_d   = head_bit(shifter_q);
                    shifter_d = drop_head(shifter_q);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = LOAD_DATA;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_load) begin
            shifter_d = drop_head(load_word);
            sdata_d   = head_bit(load_word);
            svalid_d  = 1'b1;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            shifter_q   <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sdata_q     <= 1'b0;
            svalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sdata_q     <= sdata_d;
            svalid_q    <= svalid_d;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_serializer
//   Two serializers (MSB-first and LSB-first) share one input stream. The
//   reference model is a per-lane queue of bits still owed on the serial line:
//   every accepted word appends its WIDTH bits in transmit order, reset clears
//   the queue. In any cycle the line must show the queue head with SVALID=1
//   when bits are owed, and an idle 0/0 line otherwise. BUSY means bits are
//   owed; LOAD_READY means at most one word's worth of bits is owed.
// -----------------------------------------------------------------------------
module tb_seq_serializer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] LOAD_DATA;
    logic         LOAD_VALID;

    logic ready_m, sdata_m, svalid_m, busy_m;
    logic ready_l, sdata_l, svalid_l, busy_l;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    bit          armed = 1'b0;
    bit          exp_m[$];
    bit          exp_l[$];

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(CLK), .RESET(RESET), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(ready_m), .SDATA(sdata_m), .SVALID(svalid_m), .BUSY(busy_m)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .RESET(RESET), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(ready_l), .SDATA(sdata_l), .SVALID(svalid_l), .BUSY(busy_l)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model update: decides acceptance from its own notion of
    // readiness (owed bits after this cycle's bit was consumed < W).
    always @(posedge CLK) begin
        if (RESET) begin
            armed = 1'b1;
            exp_m.delete();
            exp_l.delete();
        end else if (armed && LOAD_VALID && exp_m.size() < W) begin
            for (int i = 0; i < W; i++) begin
                exp_m.push_back(LOAD_DATA[W-1-i]);
                exp_l.push_back(LOAD_DATA[i]);
            end
        end
    end

    // Monitor: compares what each DUT presents this cycle against the queues.
    always @(negedge CLK) begin
        if (armed) begin
            chk("msb_ready", ready_m, exp_m.size() <= W);
            chk("msb_busy",  busy_m,  exp_m.size() != 0);
            if (exp_m.size() != 0) begin
                chk("msb_svalid", svalid_m, 1'b1);
                chk("msb_sdata",  sdata_m,  exp_m.pop_front());
            end else begin
                chk("msb_idle_svalid", svalid_m, 1'b0);
                chk("msb_idle_sdata",  sdata_m,  1'b0);
            end

            chk("lsb_ready", ready_l, exp_l.size() <= W);
            chk("lsb_busy",  busy_l,  exp_l.size() != 0);
            if (exp_l.size() != 0) begin
                chk("lsb_svalid", svalid_l, 1'b1);
                chk("lsb_sdata",  sdata_l,  exp_l.pop_front());
            end else begin
                chk("lsb_idle_svalid", svalid_l, 1'b0);
                chk("lsb_idle_sdata",  sdata_l,  1'b0);
            end
        end
    end

    // Inputs for one cycle, then advance to just past the next rising edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        LOAD_VALID = v;
        LOAD_DATA  = d;
        RESET      = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'h77, 1'b1);      // word offered during reset is discarded
        idle(2);

        // Single word, then return to idle (0xD0 MSB-first / 0x0B LSB-first).
        step(1'b1, 8'hD0, 1'b0);
        idle(10);
        step(1'b1, 8'h0B, 1'b0);
        idle(10);

        // Back-to-back through the holding register.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        idle(20);

        // Second word offered only in the last-bit cycle: direct reload.
        step(1'b1, 8'hFF, 1'b0);
        idle(7);
        step(1'b1, 8'h0F, 1'b0);
        idle(12);

        // Reset mid-word with the holding register full.
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'h99, 1'b0);
        idle(2);
        step(1'b1, 8'h55, 1'b1);
        idle(4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 249) == 0);
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
